sqrt_stream_frontend: RTL and testbench

Streaming wrapper that sits directly upstream and downstream of the iterative square-root core.
- Accepts operands on a valid/ready input stream and buffers them in a small FIFO.
- Launches the core one operand at a time and waits for its completion pulse or a timeout.
- Presents each root on a valid/ready output stream.
- Decouples the core's variable per-operand latency from the surrounding system.

---
 rtl/sqrt_stream_frontend.sv | 154 +++++++++++++++
 tb/tb_sqrt_stream_frontend.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sqrt_stream_frontend.sv
// Streaming front end for the iterative square-root core.
// Operands enter through a small FIFO, are launched into the core one at a
// time, and each root (or a forced timeout error) is held on the output
// stream until the downstream side accepts it.
//
// Handshake semantics: a transfer happens on a rising clk edge where valid
// and ready are both 1. in_ready_o depends only on FIFO fullness, and
// out_valid_o, once raised, stays high with stable root/err until out_ready_i
// accepts the result.
module sqrt_stream_frontend #(
  parameter int WIDTH   = 8,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  input  logic [WIDTH-1:0]           in_data_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [WIDTH/2-1:0]         out_root_o,
  output logic                       out_err_o,
  output logic                       core_start_o,
  output logic [WIDTH-1:0]           core_operand_o,
  input  logic                       core_done_i,
  input  logic [WIDTH/2-1:0]         core_root_i,
  output logic                       busy_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int RW = WIDTH / 2;
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2,
    HOLD   = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]     count_q;
  logic [TW-1:0]     tmo_q;
  logic [WIDTH-1:0]  operand_q;
  logic [RW-1:0]     root_q;
  logic              err_q;
  logic              valid_q;
  logic              full;
  logic              push;
  logic              pop;
  logic              tmo_hit;

  // Ready is purely a function of fullness, so a same-cycle pop never
  // opens a slot for a push while the FIFO is full.
  assign full     = (count_q == CW'(DEPTH));
  assign push     = in_valid_i && !full;
  // The head leaves the FIFO exactly on the IDLE -> LAUNCH transition.
  assign pop      = (state_q == IDLE) && (count_q != '0);
  assign tmo_hit  = (tmo_q == TW'(TIMEOUT - 1));

  assign in_ready_o     = !full;
  assign count_o        = count_q;
  assign busy_o         = (state_q != IDLE);
  assign core_start_o   = (state_q == LAUNCH);
  assign core_operand_o = operand_q;
  assign out_valid_o    = valid_q;
  assign out_root_o     = root_q;
  assign out_err_o      = err_q;

  // FIFO storage: written on push, never reset (contents gated by count).
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= in_data_i;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: done beats timeout in WAIT; HOLD always returns via IDLE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (count_q != '0) state_d = LAUNCH;
      LAUNCH:  state_d = WAIT;
      WAIT:    if (core_done_i || tmo_hit) state_d = HOLD;
      HOLD:    if (out_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: operand capture, timeout counter, result and output valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      operand_q <= '0;
      tmo_q     <= '0;
      root_q    <= '0;
      err_q     <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      if (pop) begin
        operand_q <= mem_q[rd_ptr_q];
      end
      unique case (state_q)
        LAUNCH: tmo_q <= '0;
        WAIT: begin
          tmo_q <= tmo_q + TW'(1);
          if (core_done_i) begin
            root_q  <= core_root_i;
            err_q   <= 1'b0;
            valid_q <= 1'b1;
          end else if (tmo_hit) begin
            root_q  <= '0;
            err_q   <= 1'b1;
            valid_q <= 1'b1;
          end
        end
        HOLD: begin
          if (out_ready_i) valid_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sqrt_stream_frontend.sv
// Bench for sqrt_stream_frontend: directed scenarios plus a randomized run.
// A core model answers launches with floor(sqrt(operand)) after a chosen
// latency (0 = never answers); a monitor pops expected results from exp_q.
`timescale 1ns/1ps
module tb_sqrt_stream_frontend;

  localparam int WIDTH   = 8;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 255;
  localparam int RW      = WIDTH / 2;
  localparam int CW      = $clog2(DEPTH) + 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic              in_valid_i, in_ready_o;
  logic [WIDTH-1:0]  in_data_i;
  logic              out_valid_o, out_ready_i;
  logic [RW-1:0]     out_root_o;
  logic              out_err_o;
  logic              core_start_o;
  logic [WIDTH-1:0]  core_operand_o;
  logic              core_done_i;
  logic [RW-1:0]     core_root_i;
  logic              busy_o;
  logic [CW-1:0]     count_o;

  sqrt_stream_frontend #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_data_i(in_data_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_root_o(out_root_o), .out_err_o(out_err_o),
    .core_start_o(core_start_o), .core_operand_o(core_operand_o),
    .core_done_i(core_done_i), .core_root_i(core_root_i),
    .busy_o(busy_o), .count_o(count_o)
  );

  // ---------------- bookkeeping ----------------
  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int start_cnt = 0;
  int hs_cnt = 0;
  int ready_mode = 1;       // 0: hold low, 1: hold high, 2: random
  bit rnd_inject = 1'b0;    // random spurious done pulses in IDLE/LAUNCH
  int inj_req = 0;
  int inj_ack = 0;

  logic [RW:0]       exp_q[$];        // {err, root}
  logic [WIDTH-1:0]  launch_op_q[$];
  int                launch_lat_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: integer square root by plain search.
  function automatic int isqrt(input int x);
    int r = 0;
    while ((r + 1) * (r + 1) <= x) r++;
    return r;
  endfunction

  // A core answering on WAIT cycle 1..TIMEOUT gives the root; otherwise error.
  function automatic logic [RW:0] expect_of(input int x, input int lat);
    if (lat >= 1 && lat <= TIMEOUT) return {1'b0, RW'(isqrt(x))};
    return {1'b1, RW'(0)};
  endfunction

  // ---------------- driver tasks ----------------
  // Called at a negedge; returns at the negedge right after the accepting edge.
  task automatic push(input logic [WIDTH-1:0] x, input int lat);
    int n = 0;
    in_valid_i = 1'b1;
    in_data_i  = x;
    while (!in_ready_o && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) begin
      tests++;
      fails++;
      $display("FAIL push_stall: operand %0d not accepted, in_ready=%0d expected 1", x, in_ready_o);
      in_valid_i = 1'b0;
      return;
    end
    exp_q.push_back(expect_of(x, lat));
    launch_op_q.push_back(x);
    launch_lat_q.push_back(lat);
    @(negedge clk);
    in_valid_i = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || busy_o || count_o != 0) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (n >= 5000) begin
      fails++;
      $display("FAIL %s_drain: %0d results pending, busy=%0d count=%0d, expected 0/0/0",
               name, exp_q.size(), busy_o, count_o);
    end
    check({name, "_busy_idle"}, busy_o, 0);
  endtask

  // ---------------- downstream ready driver ----------------
  initial begin
    out_ready_i = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      case (ready_mode)
        0:       out_ready_i = 1'b0;
        1:       out_ready_i = 1'b1;
        default: out_ready_i = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // ---------------- core model ----------------
  initial begin
    int remaining = 0;
    bit active = 1'b0;
    logic [WIDTH-1:0] op = '0;
    int lat;
    core_done_i = 1'b0;
    core_root_i = '0;
    forever begin
      @(posedge clk);
      #1;
      core_done_i = 1'b0;
      core_root_i = '0;
      if (!rst_n) begin
        active = 1'b0;
        continue;
      end
      if (active) begin
        remaining--;
        if (remaining == 0) begin
          core_done_i = 1'b1;
          core_root_i = RW'(isqrt(int'(op)));
          active = 1'b0;
        end
      end
      if (core_start_o) begin
        if (launch_op_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL launch: start with operand %0d, expected no launch", core_operand_o);
          active = 1'b0;
        end else begin
          op  = launch_op_q.pop_front();
          lat = launch_lat_q.pop_front();
          check("launch_operand", core_operand_o, op);
          active    = (lat != 0);
          remaining = lat;
        end
        // Done during LAUNCH must be ignored by the DUT.
        if (rnd_inject && $urandom_range(0, 1) == 1) begin
          core_done_i = 1'b1;
          core_root_i = RW'($urandom);
        end
      end else if (!busy_o && ((rnd_inject && $urandom_range(0, 3) == 0) || inj_req != inj_ack)) begin
        if (inj_req != inj_ack) inj_ack++;
        core_done_i = 1'b1;
        core_root_i = RW'(5);
      end
    end
  end

  // ---------------- scoreboard / monitor ----------------
  initial begin
    logic pv = 1'b0, pnr = 1'b0, pstart = 1'b0, phs = 1'b0;
    logic [RW:0] pres = '0;
    logic [RW:0] e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pv = 1'b0; pnr = 1'b0; pstart = 1'b0; phs = 1'b0;
        continue;
      end
      if (core_start_o) begin
        start_cnt++;
        check("start_single_cycle", pstart, 0);
        check("start_no_result_pending", out_valid_o, 0);
      end
      if (phs) check("valid_drop_after_accept", out_valid_o, 0);
      if (pv && pnr) check("result_stable_under_backpressure", {out_err_o, out_root_o}, pres);
      if (out_valid_o && out_ready_i) begin
        hs_cnt++;
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_result: got err=%0d root=%0d, expected no result", out_err_o, out_root_o);
        end else begin
          e = exp_q.pop_front();
          check("result_err_root", {out_err_o, out_root_o}, e);
        end
      end
      pv     = out_valid_o;
      pnr    = !out_ready_i;
      pres   = {out_err_o, out_root_o};
      pstart = core_start_o;
      phs    = out_valid_o && out_ready_i;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int t0, t1, n, s0, h0;
    in_valid_i = 1'b0;
    in_data_i  = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_count", count_o, 0);
    check("rst_in_ready", in_ready_o, 1);
    check("rst_out", {out_valid_o, out_err_o, out_root_o}, 0);
    check("rst_core", {core_start_o, core_operand_o}, 0);
    check("rst_busy", busy_o, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single operand: start is high in the cycle after the one following acceptance
    ready_mode = 1;
    push(8'd49, 8);
    check("single_start_early", core_start_o, 0);
    @(negedge clk);
    check("single_start", core_start_o, 1);
    @(negedge clk);
    check("single_start_end", core_start_o, 0);
    wait_drain("single");

    // FIFO full with the first operand stalled in the core
    push(8'd16, 40);
    push(8'd25, 3);
    push(8'd36, 5);
    push(8'd64, 2);
    push(8'd81, 7);
    check("full_count", count_o, 4);
    check("full_in_ready", in_ready_o, 0);
    in_valid_i = 1'b1;
    in_data_i  = 8'd100;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("full_reject_ready", in_ready_o, 0);
      check("full_reject_count", count_o, 4);
    end
    in_valid_i = 1'b0;
    wait_drain("full");

    // Timeout: core never answers
    push(8'd49, 0);
    n = 0;
    while (!core_start_o && n < 10) begin @(negedge clk); n++; end
    t0 = cyc;
    n = 0;
    while (!out_valid_o && n < 400) begin @(negedge clk); n++; end
    t1 = cyc;
    // LAUNCH cycle plus TIMEOUT WAIT cycles before HOLD is entered
    check("timeout_latency", t1 - t0, TIMEOUT + 1);
    wait_drain("timeout");

    // Done on the last WAIT cycle wins over timeout; one cycle later times out
    push(8'd144, TIMEOUT);
    wait_drain("collision");
    push(8'd144, TIMEOUT + 1);
    wait_drain("late_done");

    // Backpressure with two operands queued
    ready_mode = 0;
    push(8'd144, 4);
    push(8'd9, 2);
    push(8'd25, 2);
    n = 0;
    while (!out_valid_o && n < 50) begin @(negedge clk); n++; end
    s0 = start_cnt;
    for (int i = 0; i < 10; i++) begin
      check("bp_valid", out_valid_o, 1);
      check("bp_root", out_root_o, 12);
      check("bp_count", count_o, 2);
      @(negedge clk);
    end
    check("bp_no_start", start_cnt - s0, 0);
    ready_mode = 1;
    wait_drain("bp");

    // Spurious done in IDLE
    h0 = hs_cnt;
    inj_req++;
    repeat (6) @(negedge clk);
    check("spur_injected", inj_ack, inj_req);
    check("spur_busy", busy_o, 0);
    check("spur_valid", out_valid_o, 0);
    check("spur_no_result", hs_cnt - h0, 0);

    // Asynchronous reset mid-WAIT with three operands queued
    push(8'd100, 0);
    push(8'd121, 0);
    push(8'd144, 0);
    push(8'd169, 0);
    repeat (8) @(negedge clk);
    check("pre_rst_count", count_o, 3);
    check("pre_rst_busy", busy_o, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_count", count_o, 0);
    check("arst_in_ready", in_ready_o, 1);
    check("arst_out", {out_valid_o, out_err_o, out_root_o}, 0);
    check("arst_core", {core_start_o, core_operand_o}, 0);
    check("arst_busy", busy_o, 0);
    exp_q.delete();
    launch_op_q.delete();
    launch_lat_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    s0 = start_cnt;
    repeat (20) @(negedge clk);
    check("post_rst_no_start", start_cnt - s0, 0);
    check("post_rst_busy", busy_o, 0);
    push(8'd169, 6);
    wait_drain("post_rst");

    // Randomized run with random backpressure and spurious done pulses
    rnd_inject = 1'b1;
    ready_mode = 2;
    for (int i = 0; i < 40; i++) begin
      int x, lat;
      x   = $urandom_range(0, 255);
      lat = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 25);
      push(WIDTH'(x), lat);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    wait_drain("random");
    rnd_inject = 1'b0;
    ready_mode = 1;

    check("final_pending", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Watchdog
  initial begin
    #2000000;
    fails++;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog expired");
  end

endmodule
